// File: rtl/ijvm_bus_pkg.sv
// Shared encodings and default sizes for the IJVM datapath bus initiator.
// Imported by bus_master and bus_unary_alu.
package ijvm_bus_pkg;

  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_NUM_B_SRC  = 9;
  localparam int DEF_NUM_C_DST  = 9;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam logic [1:0] OP_NOT  = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/bus_unary_alu.sv
// Combinational unary operation applied to the B-bus operand.
// Arithmetic wraps modulo 2^WORD_WIDTH and produces no flags.
module bus_unary_alu
  import ijvm_bus_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic [1:0]            i_op,
  input  logic [WORD_WIDTH-1:0] i_operand,
  output logic [WORD_WIDTH-1:0] o_result
);

  always_comb begin
    o_result = i_operand;
    case (i_op)
      OP_PASS: o_result = i_operand;
      OP_INC:  o_result = i_operand + WORD_WIDTH'(1);
      OP_DEC:  o_result = i_operand - WORD_WIDTH'(1);
      OP_NOT:  o_result = ~i_operand;
      default: o_result = i_operand;
    endcase
  end

endmodule

// File: rtl/bus_master.sv
// Register-file bus initiator: reads one source over the B bus, applies a
// unary op, and writes the result over the C bus to a destination mask.
module bus_master
  import ijvm_bus_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int NUM_B_SRC   = DEF_NUM_B_SRC,
  parameter int NUM_C_DST   = DEF_NUM_C_DST,
  parameter int B_SEL_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [B_SEL_WIDTH-1:0] b_sel,
  input  logic [NUM_C_DST-1:0]   c_mask,
  input  logic [1:0]             op,
  input  logic [WORD_WIDTH-1:0]  b_bus,
  output logic [NUM_B_SRC-1:0]   b_read_enable,
  output logic [WORD_WIDTH-1:0]  c_bus,
  output logic [NUM_C_DST-1:0]   c_write_enable,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  logic [1:0]            r_state;
  logic [1:0]            r_op;
  logic [NUM_C_DST-1:0]  r_cMask;
  logic [NUM_C_DST-1:0]  r_cWe;
  logic [NUM_B_SRC-1:0]  r_bRe;
  logic [WORD_WIDTH-1:0] r_cBus;
  logic                  r_done;
  logic                  r_err;
  logic                  w_selValid;
  logic [WORD_WIDTH-1:0] w_aluResult;

  assign w_selValid = (32'(b_sel) < 32'(NUM_B_SRC));

  // The ALU works on the live B bus so the result is ready on the READ edge.
  bus_unary_alu #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_alu (
    .i_op      (r_op),
    .i_operand (b_bus),
    .o_result  (w_aluResult)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_PASS;
      r_cMask <= '0;
      r_cWe   <= '0;
      r_bRe   <= '0;
      r_cBus  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_cMask <= c_mask;
            if (w_selValid) begin
              r_bRe   <= NUM_B_SRC'(1'b1) << b_sel;
              r_state <= ST_READ;
            end else begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          r_bRe   <= '0;
          r_cBus  <= w_aluResult;
          r_cWe   <= r_cMask;
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_cWe   <= '0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_bRe   <= '0;
          r_cWe   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign b_read_enable  = r_bRe;
  assign c_bus          = r_cBus;
  assign c_write_enable = r_cWe;
  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign err            = r_err;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with a small register-file model that drives
// the B bus on the falling edge and captures the C bus on the rising edge.
module tb_bus_master;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] bSel;
  logic [8:0] cMask;
  logic [1:0] op;
  logic [7:0] bBus;
  logic [8:0] bReadEnable;
  logic [7:0] cBus;
  logic [8:0] cWriteEnable;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] regs [0:8];
  logic [7:0] snap [0:8];
  int         testsRun;
  int         testsFailed;
  int         violations;

  bus_master dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .b_sel          (bSel),
    .c_mask         (cMask),
    .op             (op),
    .b_bus          (bBus),
    .b_read_enable  (bReadEnable),
    .c_bus          (cBus),
    .c_write_enable (cWriteEnable),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: selected source drives the B bus from the falling edge.
  always @(negedge clk) begin
    bBus = 8'h00;
    for (int i = 0; i < 9; i++)
      if (bReadEnable[i]) bBus = regs[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 9; i++)
      if (cWriteEnable[i]) regs[i] = cBus;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if ((bReadEnable != 9'h000 && cWriteEnable != 9'h000) || !$onehot0(bReadEnable))
        violations++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] sel,
                               input logic [8:0] mask, input logic [1:0] o);
    start = s;
    bSel  = sel;
    cMask = mask;
    op    = o;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    for (int i = 0; i < 9; i++) regs[i] = 8'hAA;
    tick();
    tick();
    testsRun++;
    if ({bReadEnable, cWriteEnable, cBus, busy, done, err} !== 29'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs got bre=%h cwe=%h cbus=%h busy=%b done=%b err=%b expected all zero",
               bReadEnable, cWriteEnable, cBus, busy, done, err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pass();
    regs[2] = 8'h5A;
    applyStimulus(1'b1, 4'd2, 9'h010, 2'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    testsRun++;
    if (bReadEnable !== 9'h004 || busy !== 1'b1 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pass_read got bre=%h busy=%b done=%b expected bre=004 busy=1 done=0",
               bReadEnable, busy, done);
    end
    tick();
    testsRun++;
    if (bReadEnable !== 9'h000 || cBus !== 8'h5A || cWriteEnable !== 9'h010) begin
      testsFailed++;
      $display("[TB] FAIL pass_write got bre=%h cbus=%h cwe=%h expected bre=000 cbus=5a cwe=010",
               bReadEnable, cBus, cWriteEnable);
    end
    tick();
    testsRun++;
    if (done !== 1'b1 || cWriteEnable !== 9'h000 || busy !== 1'b0 || regs[4] !== 8'h5A || cBus !== 8'h5A) begin
      testsFailed++;
      $display("[TB] FAIL pass_done got done=%b cwe=%h busy=%b reg4=%h cbus=%h expected done=1 cwe=000 busy=0 reg4=5a cbus=5a",
               done, cWriteEnable, busy, regs[4], cBus);
    end
    tick();
    testsRun++;
    if (done !== 1'b0 || err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pass_done_pulse got done=%b err=%b expected 0 0", done, err);
    end
  endtask

  task automatic runOp(input logic [3:0] sel, input logic [8:0] mask, input logic [1:0] o);
    applyStimulus(1'b1, sel, mask, o);
    tick();
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    tick();
    tick();
  endtask

  task automatic test_arith();
    regs[5] = 8'hFF;
    regs[0] = 8'hAA;
    regs[1] = 8'hAA;
    runOp(4'd5, 9'h003, 2'd1);
    testsRun++;
    if (regs[0] !== 8'h00 || regs[1] !== 8'h00 || cBus !== 8'h00 || done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL inc_wrap got r0=%h r1=%h cbus=%h done=%b expected 00 00 00 1",
               regs[0], regs[1], cBus, done);
    end
    regs[6] = 8'h00;
    regs[8] = 8'hAA;
    runOp(4'd6, 9'h100, 2'd2);
    testsRun++;
    if (regs[8] !== 8'hFF || cBus !== 8'hFF) begin
      testsFailed++;
      $display("[TB] FAIL dec_wrap got r8=%h cbus=%h expected ff ff", regs[8], cBus);
    end
    regs[7] = 8'h0F;
    regs[3] = 8'hAA;
    runOp(4'd7, 9'h008, 2'd3);
    testsRun++;
    if (regs[3] !== 8'hF0 || cBus !== 8'hF0) begin
      testsFailed++;
      $display("[TB] FAIL not_op got r3=%h cbus=%h expected f0 f0", regs[3], cBus);
    end
    regs[2] = 8'h7F;
    regs[5] = 8'hAA;
    runOp(4'd2, 9'h020, 2'd1);
    testsRun++;
    if (regs[5] !== 8'h80) begin
      testsFailed++;
      $display("[TB] FAIL inc_carry got r5=%h expected 80", regs[5]);
    end
    tick();
  endtask

  task automatic test_err();
    applyStimulus(1'b1, 4'd12, 9'h1FF, 2'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    testsRun++;
    if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || bReadEnable !== 9'h000 || cWriteEnable !== 9'h000) begin
      testsFailed++;
      $display("[TB] FAIL err_pulse got err=%b done=%b busy=%b bre=%h cwe=%h expected 1 1 0 000 000",
               err, done, busy, bReadEnable, cWriteEnable);
    end
    tick();
    testsRun++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || bReadEnable !== 9'h000 || cWriteEnable !== 9'h000) begin
      testsFailed++;
      $display("[TB] FAIL err_clear got err=%b done=%b busy=%b bre=%h cwe=%h expected 0 0 0 000 000",
               err, done, busy, bReadEnable, cWriteEnable);
    end
    applyStimulus(1'b1, 4'd9, 9'h001, 2'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    testsRun++;
    if (err !== 1'b1 || busy !== 1'b0 || bReadEnable !== 9'h000) begin
      testsFailed++;
      $display("[TB] FAIL err_sel9 got err=%b busy=%b bre=%h expected 1 0 000", err, busy, bReadEnable);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int doneCount;
    int acceptCount;
    doneCount   = 0;
    acceptCount = 0;
    regs[2] = 8'h5A;
    regs[5] = 8'hAA;
    applyStimulus(1'b1, 4'd2, 9'h020, 2'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done) doneCount++;
      if (bReadEnable != 9'h000) acceptCount++;
    end
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    testsRun++;
    if (doneCount !== 3 || acceptCount !== 3) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count got done=%0d accepts=%0d expected 3 3", doneCount, acceptCount);
    end
    testsRun++;
    if (regs[5] !== 8'h5B || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_result got r5=%h busy=%b expected 5b 0", regs[5], busy);
    end
    tick();
    testsRun++;
    if (busy !== 1'b0 || done !== 1'b0 || bReadEnable !== 9'h000) begin
      testsFailed++;
      $display("[TB] FAIL b2b_idle got busy=%b done=%b bre=%h expected 0 0 000", busy, done, bReadEnable);
    end
  endtask

  task automatic test_ignore_busy();
    regs[2] = 8'h33;
    regs[1] = 8'hAA;
    applyStimulus(1'b1, 4'd2, 9'h002, 2'd0);
    tick();
    applyStimulus(1'b1, 4'd3, 9'h001, 2'd3);
    tick();
    testsRun++;
    if (cWriteEnable !== 9'h002 || cBus !== 8'h33 || bReadEnable !== 9'h000) begin
      testsFailed++;
      $display("[TB] FAIL busy_ignore_read got cwe=%h cbus=%h bre=%h expected 002 33 000",
               cWriteEnable, cBus, bReadEnable);
    end
    tick();
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    testsRun++;
    if (done !== 1'b1 || busy !== 1'b0 || regs[1] !== 8'h33 || bReadEnable !== 9'h000) begin
      testsFailed++;
      $display("[TB] FAIL busy_ignore_write got done=%b busy=%b r1=%h bre=%h expected 1 0 33 000",
               done, busy, regs[1], bReadEnable);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    regs[2] = 8'h5A;
    regs[6] = 8'h11;
    applyStimulus(1'b1, 4'd2, 9'h040, 2'd3);
    tick();
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    tick();
    testsRun++;
    if (cWriteEnable !== 9'h040 || cBus !== 8'hA5) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_pre got cwe=%h cbus=%h expected 040 a5", cWriteEnable, cBus);
    end
    #2;
    reset = 1'b1;
    #1;
    testsRun++;
    if (cWriteEnable !== 9'h000 || cBus !== 8'h00 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_async got cwe=%h cbus=%h busy=%b expected 000 00 0",
               cWriteEnable, cBus, busy);
    end
    tick();
    reset = 1'b0;
    testsRun++;
    if (regs[6] !== 8'h11 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_dest got r6=%h done=%b expected 11 0", regs[6], done);
    end
    tick();
    runOp(4'd2, 9'h040, 2'd0);
    testsRun++;
    if (regs[6] !== 8'h5A || done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_recover got r6=%h done=%b expected 5a 1", regs[6], done);
    end
    tick();
  endtask

  task automatic test_zero_mask();
    int diffs;
    diffs = 0;
    regs[2] = 8'h3C;
    for (int i = 0; i < 9; i++) snap[i] = regs[i];
    applyStimulus(1'b1, 4'd2, 9'h000, 2'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 9'h000, 2'd0);
    testsRun++;
    if (bReadEnable !== 9'h004) begin
      testsFailed++;
      $display("[TB] FAIL zmask_read got bre=%h expected 004", bReadEnable);
    end
    tick();
    testsRun++;
    if (cWriteEnable !== 9'h000 || cBus !== 8'h3C) begin
      testsFailed++;
      $display("[TB] FAIL zmask_write got cwe=%h cbus=%h expected 000 3c", cWriteEnable, cBus);
    end
    tick();
    for (int i = 0; i < 9; i++)
      if (regs[i] !== snap[i]) diffs++;
    testsRun++;
    if (done !== 1'b1 || diffs !== 0) begin
      testsFailed++;
      $display("[TB] FAIL zmask_done got done=%b changedRegs=%0d expected 1 0", done, diffs);
    end
    tick();
  endtask

  task automatic test_invariants();
    testsRun++;
    if (violations !== 0) begin
      testsFailed++;
      $display("[TB] FAIL enable_invariant got %0d violations expected 0", violations);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    violations  = 0;
    bBus        = 8'h00;
    test_reset();
    test_pass();
    test_arith();
    test_err();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_zero_mask();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
